// File: rtl/fios_mm_seq.sv
`default_nettype none
// ============================================================================
// fios_mm_seq : word-serial FIOS Montgomery multiplier, RES = A*B*2^(-S*W) mod P
// Revision    : 1.0
// ============================================================================
module fios_mm_seq #(
    parameter int WORD_W = 17,
    parameter int S      = 8
) (
    input  logic                clock_i,
    input  logic                reset_n_i,
    input  logic                start_i,
    input  logic [WORD_W-1:0]   p_prime_0_i,
    input  logic [S*WORD_W-1:0] a_i,
    input  logic [S*WORD_W-1:0] b_i,
    input  logic [S*WORD_W-1:0] p_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [S*WORD_W-1:0] res_o
);
    localparam int W  = WORD_W;
    localparam int IW = $clog2(S);
    localparam int JW = $clog2(S + 1);
    localparam int SW = 2 * W + 1;
    localparam logic [JW-1:0] J_LAST = JW'(S);
    localparam logic [JW-1:0] K_LAST = JW'(S - 1);
    localparam logic [IW-1:0] I_LAST = IW'(S - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        SUB  = 2'd2
    } state_t;

    state_t        state;
    logic [W-1:0]  a_w   [S];
    logic [W-1:0]  b_w   [S];
    logic [W-1:0]  p_w   [S];
    logic [W-1:0]  t_w   [S];
    logic [W-1:0]  d_w   [S];
    logic [W-1:0]  res_w [S];
    logic [W-1:0]  pp;
    logic [1:0]    t_top;
    logic [W:0]    carry;
    logic [W-1:0]  m;
    logic [IW-1:0] i;
    logic [JW-1:0] j;
    logic          borrow;

    logic [IW-1:0] jidx;
    logic [W-1:0]  t_cur;
    logic [W-1:0]  a_cur;
    logic [W-1:0]  b_cur;
    logic [W-1:0]  p_cur;
    logic [W-1:0]  m_new;
    logic [W-1:0]  m_use;
    logic [W:0]    c_in;
    logic [SW-1:0] s_base;
    logic [SW-1:0] s_full;
    logic [W+1:0]  u;
    logic [W:0]    diff;
    logic          use_d;

    // One datapath serves every MUL step; step j=0 forces carry-in to 0 and uses the fresh m.
    always_comb begin
        jidx   = (j < J_LAST) ? j[IW-1:0] : '0;
        t_cur  = t_w[jidx];
        a_cur  = a_w[jidx];
        p_cur  = p_w[jidx];
        b_cur  = b_w[i];
        c_in   = (j == '0) ? '0 : carry;
        s_base = SW'(t_cur) + SW'(a_cur) * SW'(b_cur) + SW'(c_in);
        m_new  = s_base[W-1:0] * pp;
        m_use  = (j == '0) ? m_new : m;
        s_full = s_base + SW'(m_use) * SW'(p_cur);
        u      = (W+2)'(t_top) + (W+2)'(carry);
        diff   = {1'b0, t_cur} - {1'b0, p_cur} - (W+1)'(borrow);
        use_d  = (t_top != 2'd0) || !diff[W];
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b0;
            pp     <= '0;
            t_top  <= '0;
            carry  <= '0;
            m      <= '0;
            i      <= '0;
            j      <= '0;
            borrow <= 1'b0;
            for (int k = 0; k < S; k++) begin
                a_w[k]   <= '0;
                b_w[k]   <= '0;
                p_w[k]   <= '0;
                t_w[k]   <= '0;
                d_w[k]   <= '0;
                res_w[k] <= '0;
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        for (int k = 0; k < S; k++) begin
                            a_w[k] <= a_i[k*W +: W];
                            b_w[k] <= b_i[k*W +: W];
                            p_w[k] <= p_i[k*W +: W];
                            t_w[k] <= '0;
                        end
                        pp     <= p_prime_0_i;
                        t_top  <= '0;
                        carry  <= '0;
                        m      <= '0;
                        i      <= '0;
                        j      <= '0;
                        state  <= MUL;
                        busy_o <= 1'b1;
                    end
                end
                MUL: begin
                    if (j == '0) begin
                        m     <= m_new;
                        carry <= s_full[2*W:W];
                        j     <= j + 1'b1;
                    end else if (j != J_LAST) begin
                        t_w[IW'(j - 1'b1)] <= s_full[W-1:0];
                        carry <= s_full[2*W:W];
                        j     <= j + 1'b1;
                    end else begin
                        t_w[S-1] <= u[W-1:0];
                        t_top    <= u[W+1:W];
                        j        <= '0;
                        if (i == I_LAST) begin
                            i      <= '0;
                            borrow <= 1'b0;
                            state  <= SUB;
                        end else begin
                            i <= i + 1'b1;
                        end
                    end
                end
                SUB: begin
                    d_w[jidx] <= diff[W-1:0];
                    borrow    <= diff[W];
                    if (j == K_LAST) begin
                        // T < 2P, so either T or T-P is the reduced result.
                        for (int k = 0; k < S; k++) begin
                            res_w[k] <= use_d ? d_w[k] : t_w[k];
                        end
                        res_w[S-1] <= use_d ? diff[W-1:0] : t_w[S-1];
                        j      <= '0;
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < S; g++) begin : g_res
        assign res_o[g*W +: W] = res_w[g];
    end

endmodule
`default_nettype wire

// File: tb/tb_fios_mm_seq.sv
`default_nettype none
// Bench for fios_mm_seq: small W=4/S=2 instance with hand vectors, default instance against a bit-serial reference.
module tb_fios_mm_seq;
    localparam int NRAND = 600;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         sm_start, sm_busy, sm_done;
    logic [3:0]   sm_pp;
    logic [7:0]   sm_a, sm_b, sm_p, sm_res;
    logic         bg_start, bg_busy, bg_done;
    logic [16:0]  bg_pp;
    logic [135:0] bg_a, bg_b, bg_p, bg_res;

    int n_vec = 0;
    int n_err = 0;

    fios_mm_seq #(.WORD_W(4), .S(2)) u_small (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(sm_start), .p_prime_0_i(sm_pp),
        .a_i(sm_a), .b_i(sm_b), .p_i(sm_p),
        .busy_o(sm_busy), .done_o(sm_done), .res_o(sm_res)
    );

    fios_mm_seq #(.WORD_W(17), .S(8)) u_big (
        .clock_i(clk), .reset_n_i(rst_n), .start_i(bg_start), .p_prime_0_i(bg_pp),
        .a_i(bg_a), .b_i(bg_b), .p_i(bg_p),
        .busy_o(bg_busy), .done_o(bg_done), .res_o(bg_res)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic [3:0] pp;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic launch(input bit big, input logic [135:0] a, input logic [135:0] b,
                          input logic [135:0] p, input logic [16:0] pp);
        if (big) begin
            bg_a = a; bg_b = b; bg_p = p; bg_pp = pp; bg_start = 1'b1;
        end else begin
            sm_a = a[7:0]; sm_b = b[7:0]; sm_p = p[7:0]; sm_pp = pp[3:0]; sm_start = 1'b1;
        end
        @(posedge clk); #1;
        sm_start = 1'b0;
        bg_start = 1'b0;
    endtask

    // Cycles from the last sampled edge to the edge after which done is seen.
    task automatic wait_done(input bit big, output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!(big ? bg_done : sm_done) && lat < 300);
    endtask

    function automatic logic [135:0] rand136();
        return {8'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [135:0] rand_p();
        logic [135:0] p;
        p = rand136();
        p[135] = 1'b1;
        p[0]   = 1'b1;
        return p;
    endfunction

    function automatic logic [16:0] pprime(input logic [16:0] p0);
        logic [16:0] inv;
        inv = p0;
        for (int k = 0; k < 4; k++) inv = inv * (17'd2 - p0 * inv);
        return 17'd0 - inv;
    endfunction

    // Reference: reduce A*B mod P, then halve 136 times modulo P.
    function automatic logic [135:0] mont_ref(input logic [135:0] a, input logic [135:0] b,
                                              input logic [135:0] p);
        logic [271:0] prod;
        logic [136:0] x;
        prod = {136'b0, a} * {136'b0, b};
        x = 137'(prod % {136'b0, p});
        for (int k = 0; k < 136; k++) begin
            if (x[0]) x = x + {1'b0, p};
            x = x >> 1;
        end
        return x[135:0];
    endfunction

    initial begin
        logic [135:0] a, b, p, exp;
        logic [16:0]  pp;
        int           lat;

        // P=13: R^-1 = 3 mod 13.  P=251: R^-1 = 201 mod 251; 250*250 ends with t_S=1.
        tbl[0] = '{a: 8'd1,   b: 8'd1,   p: 8'd13,  pp: 4'd11, exp: 8'd3};
        tbl[1] = '{a: 8'd9,   b: 8'd9,   p: 8'd13,  pp: 4'd11, exp: 8'd9};
        tbl[2] = '{a: 8'd12,  b: 8'd12,  p: 8'd13,  pp: 4'd11, exp: 8'd3};
        tbl[3] = '{a: 8'd0,   b: 8'd5,   p: 8'd13,  pp: 4'd11, exp: 8'd0};
        tbl[4] = '{a: 8'd250, b: 8'd250, p: 8'd251, pp: 4'd13, exp: 8'd201};
        tbl[5] = '{a: 8'd1,   b: 8'd1,   p: 8'd251, pp: 4'd13, exp: 8'd201};
        tbl[6] = '{a: 8'd2,   b: 8'd3,   p: 8'd251, pp: 4'd13, exp: 8'd202};

        rst_n = 1'b0;
        sm_start = 1'b0; sm_a = '0; sm_b = '0; sm_p = '0; sm_pp = '0;
        bg_start = 1'b0; bg_a = '0; bg_b = '0; bg_p = '0; bg_pp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sm_busy", sm_busy, 0);
        check("rst_sm_done", sm_done, 0);
        check("rst_sm_res",  sm_res,  0);
        check("rst_bg_busy", bg_busy, 0);
        check("rst_bg_done", bg_done, 0);
        check("rst_bg_res",  bg_res,  0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int n = 0; n < 7; n++) begin
            launch(1'b0, 136'(tbl[n].a), 136'(tbl[n].b), 136'(tbl[n].p), 17'(tbl[n].pp));
            check($sformatf("sm%0d_busy", n), sm_busy, 1);
            wait_done(1'b0, lat);
            check($sformatf("sm%0d_res", n), sm_res, 136'(tbl[n].exp));
            check($sformatf("sm%0d_lat", n), 136'(lat), 136'(8));
            @(posedge clk); #1;
            check($sformatf("sm%0d_pulse", n), sm_done, 0);
        end

        // Asynchronous reset in the middle of MUL.
        launch(1'b0, 136'd9, 136'd9, 136'd13, 17'd11);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("arst_busy", sm_busy, 0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_done", sm_done, 0);
        check("arst_res",  sm_res,  0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_busy_after", sm_busy, 0);
        launch(1'b0, 136'd12, 136'd12, 136'd13, 17'd11);
        wait_done(1'b0, lat);
        check("arst_next_res", sm_res, 136'd3);
        check("arst_next_lat", 136'(lat), 136'(8));

        // Default size, A = 0.
        p  = rand_p();
        pp = pprime(p[16:0]);
        b  = rand136() % p;
        launch(1'b1, 136'd0, b, p, pp);
        wait_done(1'b1, lat);
        check("bg_zero_res", bg_res, 136'd0);
        check("bg_zero_lat", 136'(lat), 136'(80));

        // A second start while busy must be ignored.
        a   = rand136() % p;
        b   = rand136() % p;
        exp = mont_ref(a, b, p);
        @(posedge clk); #1;
        launch(1'b1, a, b, p, pp);
        repeat (10) @(posedge clk);
        #1;
        bg_a = rand136() % p;
        bg_start = 1'b1;
        @(posedge clk); #1;
        bg_start = 1'b0;
        wait_done(1'b1, lat);
        check("ign_res", bg_res, exp);
        check("ign_lat", 136'(lat + 11), 136'(80));
        @(posedge clk); #1;
        check("ign_pulse", bg_done, 0);
        check("ign_idle",  bg_busy, 0);

        // Back-to-back regression: each next start is raised in the done cycle.
        p   = rand_p();
        pp  = pprime(p[16:0]);
        a   = rand136() % p;
        b   = rand136() % p;
        exp = mont_ref(a, b, p);
        launch(1'b1, a, b, p, pp);
        for (int n = 0; n < NRAND; n++) begin
            wait_done(1'b1, lat);
            check($sformatf("rnd%0d_res", n), bg_res, exp);
            check($sformatf("rnd%0d_lat", n), 136'(lat), 136'(80));
            if (n < NRAND - 1) begin
                p   = rand_p();
                pp  = pprime(p[16:0]);
                a   = rand136() % p;
                b   = rand136() % p;
                exp = mont_ref(a, b, p);
                launch(1'b1, a, b, p, pp);
                check($sformatf("rnd%0d_pulse", n), bg_done, 0);
            end else begin
                @(posedge clk); #1;
                check($sformatf("rnd%0d_pulse", n), bg_done, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
